// File: rtl/data_memory_ext.sv
// Byte-addressable data memory with a post-reset clear sweep and registered loads.
// Accepts 1-, 2- and 4-byte accesses and checks them for alignment and address range.
// Loads are sign- or zero-extended.
//
// Ports:
//   clk         clock; all state changes on the rising edge
//   reset       asynchronous, active-high reset
//   MemRead     read request
//   MemWrite    write request
//   Address     byte address
//   Write_data  store data, right-aligned
//   Size        00 byte, 01 half, 10 word, 11 reserved
//   Unsigned    1 zero-extends loads, 0 sign-extends them
//   Read_data   registered, extended load result; holds when no read completes
//   Read_valid  one-cycle pulse qualifying Read_data
//   Busy        high while the clear sweep runs; requests are ignored
//   Misaligned  one-cycle pulse: bad alignment or reserved Size
//   OutOfRange  one-cycle pulse: address outside the memory window
module data_memory_ext #(
  parameter int unsigned RAM_SIZE     = 256,
  parameter int unsigned RAM_SIZE_BIT = 8,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] Read_data,
  output logic        Read_valid,
  output logic        Busy,
  output logic        Misaligned,
  output logic        OutOfRange
);

  typedef enum logic {StClear, StIdle} state_e;

  localparam logic [RAM_SIZE_BIT-1:0] LastIdx     = RAM_SIZE_BIT'(RAM_SIZE - 1);
  localparam logic [31:0]             WindowBytes = 32'(4 * RAM_SIZE);

  logic [31:0] mem_q [RAM_SIZE];

  state_e                  state_q, state_d;
  logic [RAM_SIZE_BIT-1:0] clr_cnt_q, clr_cnt_d;
  logic [31:0]             read_data_q, read_data_d;
  logic                    read_valid_q, read_valid_d;
  logic                    misaligned_q, misaligned_d;
  logic                    out_of_range_q, out_of_range_d;

  logic [31:0]             offset;
  logic [RAM_SIZE_BIT-1:0] word_idx;
  logic [1:0]              lane;
  logic                    oor, mis, err, accept;
  logic [31:0]             rd_word, shifted, load_val;
  logic [31:0]             wr_rep, merged;
  logic [3:0]              byte_en;
  logic                    mem_we;
  logic [RAM_SIZE_BIT-1:0] mem_waddr;
  logic [31:0]             mem_wdata;

  // Address decode, error classification, load extraction and store merge.
  always_comb begin
    offset   = Address - BASE_ADDR;  // wraps, so addresses below BASE_ADDR land out of range
    word_idx = offset[RAM_SIZE_BIT+1:2];
    lane     = offset[1:0];
    oor      = offset >= WindowBytes;
    case (Size)
      2'b00:   mis = 1'b0;
      2'b01:   mis = lane[0];
      2'b10:   mis = (lane != 2'b00);
      default: mis = 1'b1;
    endcase
    err    = oor | mis;
    accept = (state_q == StIdle) && (MemRead || MemWrite);

    rd_word = mem_q[word_idx];
    shifted = rd_word >> {lane, 3'b000};
    case (Size)
      2'b00:   load_val = Unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = Unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase

    // Replicate the store data across lanes, then pick lanes with the byte enables.
    case (Size)
      2'b00: begin
        wr_rep  = {4{Write_data[7:0]}};
        byte_en = 4'b0001 << lane;
      end
      2'b01: begin
        wr_rep  = {2{Write_data[15:0]}};
        byte_en = 4'b0011 << lane;
      end
      default: begin
        wr_rep  = Write_data;
        byte_en = 4'b1111;
      end
    endcase
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = byte_en[b] ? wr_rep[8*b +: 8] : rd_word[8*b +: 8];
    end
  end

  // Next state: the clear sweep owns the write port while it runs.
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    mem_we    = 1'b0;
    mem_waddr = word_idx;
    mem_wdata = merged;
    case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_cnt_q;
        mem_wdata = 32'h0;
        clr_cnt_d = clr_cnt_q + RAM_SIZE_BIT'(1);
        if (clr_cnt_q == LastIdx) state_d = StIdle;
      end
      default: begin
        mem_we = accept && MemWrite && !err;
      end
    endcase

    read_valid_d   = accept && MemRead;
    read_data_d    = read_data_q;
    // Read-before-write: rd_word is the pre-edge contents even when a write is accepted too.
    if (accept && MemRead) read_data_d = err ? 32'h0 : load_val;
    misaligned_d   = accept && mis && !oor;
    out_of_range_d = accept && oor;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= StClear;
      clr_cnt_q      <= '0;
      read_data_q    <= 32'h0;
      read_valid_q   <= 1'b0;
      misaligned_q   <= 1'b0;
      out_of_range_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      clr_cnt_q      <= clr_cnt_d;
      read_data_q    <= read_data_d;
      read_valid_q   <= read_valid_d;
      misaligned_q   <= misaligned_d;
      out_of_range_q <= out_of_range_d;
    end
  end

  // Storage has no reset; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign Read_data  = read_data_q;
  assign Read_valid = read_valid_q;
  assign Busy       = (state_q == StClear);
  assign Misaligned = misaligned_q;
  assign OutOfRange = out_of_range_q;

endmodule

// File: tb/tb_data_memory_ext.sv
module tb_data_memory_ext;

  localparam logic [1:0] SzB = 2'd0;
  localparam logic [1:0] SzH = 2'd1;
  localparam logic [1:0] SzW = 2'd2;
  localparam logic [1:0] SzR = 2'd3;

  logic        clk, reset;
  logic        mem_read, mem_write, uns;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic [31:0] rd1, rd2;
  logic        rv1, rv2, busy1, busy2, mis1, mis2, oor1, oor2;

  int n_checks = 0;
  int n_fail   = 0;

  data_memory_ext dut (
    .clk(clk), .reset(reset), .MemRead(mem_read), .MemWrite(mem_write), .Address(addr),
    .Write_data(wdata), .Size(size), .Unsigned(uns), .Read_data(rd1), .Read_valid(rv1),
    .Busy(busy1), .Misaligned(mis1), .OutOfRange(oor1)
  );

  data_memory_ext #(.BASE_ADDR(32'h0000_1000)) dut_base (
    .clk(clk), .reset(reset), .MemRead(mem_read), .MemWrite(mem_write), .Address(addr),
    .Write_data(wdata), .Size(size), .Unsigned(uns), .Read_data(rd2), .Read_valid(rv2),
    .Busy(busy2), .Misaligned(mis2), .OutOfRange(oor2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic        e_valid;
    logic [31:0] e_data;
    logic        e_mis;
    logic        e_oor;
  } vec_t;

  vec_t vecs [28];

  function automatic vec_t mk(logic r, logic w, logic [31:0] a, logic [31:0] d, logic [1:0] s,
                              logic u, logic ev, logic [31:0] ed, logic em, logic eo);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.size = s; v.uns = u;
    v.e_valid = ev; v.e_data = ed; v.e_mis = em; v.e_oor = eo;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] s, input logic u);
    mem_read = r; mem_write = w; addr = a; wdata = d; size = s; uns = u;
  endtask

  // Drive a request, let one edge pass, sample just after it.
  task automatic step(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic u);
    drive(r, w, a, d, s, u);
    @(posedge clk);
    #1;
  endtask

  // Called just after a posedge that followed reset release; counts Busy-high samples.
  task automatic count_busy(output int n, output int spurious);
    n = 0;
    spurious = 0;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (!busy1) break;
      n++;
      if (rv1 || mis1 || oor1) spurious++;
    end
  endtask

  int nb, sp;

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 32'h0, SzW, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("reset Read_data", rd1, 32'h0);
    check("reset Read_valid", {31'h0, rv1}, 32'h0);
    check("reset Busy", {31'h0, busy1}, 32'h1);
    check("reset Misaligned", {31'h0, mis1}, 32'h0);
    check("reset OutOfRange", {31'h0, oor1}, 32'h0);

    reset = 1'b0;
    count_busy(nb, sp);
    check("busy cycles", nb, 256);
    check("base inst idle", {31'h0, busy2}, 32'h0);

    //            rd    wr    addr      wdata          size uns  ev    data           mis   oor
    vecs[0]  = mk(1'b1, 1'b0, 32'h040, 32'h0,        SzW, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 32'h010, 32'h80FF7F01, SzW, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h010, 32'h0,        SzB, 1'b0, 1'b1, 32'h00000001, 1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 32'h011, 32'h0,        SzB, 1'b0, 1'b1, 32'h0000007F, 1'b0, 1'b0);
    vecs[4]  = mk(1'b1, 1'b0, 32'h012, 32'h0,        SzB, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
    vecs[5]  = mk(1'b1, 1'b0, 32'h013, 32'h0,        SzB, 1'b0, 1'b1, 32'hFFFFFF80, 1'b0, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h012, 32'h0,        SzB, 1'b1, 1'b1, 32'h000000FF, 1'b0, 1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 32'h012, 32'h0,        SzH, 1'b1, 1'b1, 32'h000080FF, 1'b0, 1'b0);
    vecs[8]  = mk(1'b1, 1'b0, 32'h012, 32'h0,        SzH, 1'b0, 1'b1, 32'hFFFF80FF, 1'b0, 1'b0);
    vecs[9]  = mk(1'b0, 1'b1, 32'h020, 32'h11223344, SzW, 1'b0, 1'b0, 32'hFFFF80FF, 1'b0, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 32'h022, 32'h1234BEEF, SzH, 1'b0, 1'b0, 32'hFFFF80FF, 1'b0, 1'b0);
    vecs[11] = mk(1'b1, 1'b0, 32'h020, 32'h0,        SzW, 1'b1, 1'b1, 32'hBEEF3344, 1'b0, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 32'h022, 32'h0,        SzH, 1'b0, 1'b1, 32'hFFFFBEEF, 1'b0, 1'b0);
    vecs[13] = mk(1'b0, 1'b1, 32'h021, 32'hFFFFFFA5, SzB, 1'b0, 1'b0, 32'hFFFFBEEF, 1'b0, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 32'h020, 32'h0,        SzW, 1'b0, 1'b1, 32'hBEEFA544, 1'b0, 1'b0);
    vecs[15] = mk(1'b0, 1'b1, 32'h005, 32'hDEADBEEF, SzW, 1'b0, 1'b0, 32'hBEEFA544, 1'b1, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 32'h004, 32'h0,        SzW, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b0);
    vecs[17] = mk(1'b1, 1'b0, 32'h010, 32'h0,        SzR, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
    vecs[18] = mk(1'b1, 1'b0, 32'h011, 32'h0,        SzH, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0);
    vecs[19] = mk(1'b1, 1'b0, 32'h400, 32'h0,        SzW, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1);
    vecs[20] = mk(1'b1, 1'b0, 32'h401, 32'h0,        SzW, 1'b0, 1'b1, 32'h00000000, 1'b0, 1'b1);
    vecs[21] = mk(1'b0, 1'b1, 32'h3FC, 32'hCAFEF00D, SzW, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0);
    vecs[22] = mk(1'b1, 1'b0, 32'h3FC, 32'h0,        SzW, 1'b0, 1'b1, 32'hCAFEF00D, 1'b0, 1'b0);
    vecs[23] = mk(1'b1, 1'b1, 32'h010, 32'h01020304, SzW, 1'b0, 1'b1, 32'h80FF7F01, 1'b0, 1'b0);
    vecs[24] = mk(1'b1, 1'b0, 32'h010, 32'h0,        SzW, 1'b0, 1'b1, 32'h01020304, 1'b0, 1'b0);
    vecs[25] = mk(1'b0, 1'b0, 32'h010, 32'h0,        SzW, 1'b0, 1'b0, 32'h01020304, 1'b0, 1'b0);
    vecs[26] = mk(1'b0, 1'b1, 32'h400, 32'h1,        SzW, 1'b0, 1'b0, 32'h01020304, 1'b0, 1'b1);
    vecs[27] = mk(1'b1, 1'b0, 32'h012, 32'h0,        SzH, 1'b1, 1'b1, 32'h00000102, 1'b0, 1'b0);

    // Back-to-back: one vector per clock, starting right after Busy falls.
    foreach (vecs[i]) begin
      step(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns);
      check($sformatf("vec%0d valid", i), {31'h0, rv1}, {31'h0, vecs[i].e_valid});
      check($sformatf("vec%0d data", i), rd1, vecs[i].e_data);
      check($sformatf("vec%0d misaligned", i), {31'h0, mis1}, {31'h0, vecs[i].e_mis});
      check($sformatf("vec%0d outofrange", i), {31'h0, oor1}, {31'h0, vecs[i].e_oor});
    end

    // Window shifted to 0x1000-0x13FF.
    step(1'b0, 1'b1, 32'h1000, 32'h55AA55AA, SzW, 1'b0);
    check("base wr oor", {31'h0, oor2}, 32'h0);
    check("nobase wr oor", {31'h0, oor1}, 32'h1);
    step(1'b1, 1'b0, 32'h1000, 32'h0, SzW, 1'b0);
    check("base rd data", rd2, 32'h55AA55AA);
    check("base rd valid", {31'h0, rv2}, 32'h1);
    check("nobase rd data", rd1, 32'h0);
    step(1'b1, 1'b0, 32'h13FC, 32'h0, SzW, 1'b0);
    check("base top oor", {31'h0, oor2}, 32'h0);
    check("base top data", rd2, 32'h0);
    step(1'b1, 1'b0, 32'h1400, 32'h0, SzW, 1'b0);
    check("base above oor", {31'h0, oor2}, 32'h1);
    step(1'b1, 1'b0, 32'h0FFC, 32'h0, SzW, 1'b0);
    check("base below oor", {31'h0, oor2}, 32'h1);
    check("base below data", rd2, 32'h0);

    // Asynchronous reset mid-access: outputs clear without a clock edge.
    step(1'b1, 1'b0, 32'h010, 32'h0, SzW, 1'b0);
    check("pre-reset data", rd1, 32'h01020304);
    drive(1'b1, 1'b0, 32'h010, 32'h0, SzW, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    check("async Read_data", rd1, 32'h0);
    check("async Read_valid", {31'h0, rv1}, 32'h0);
    check("async Busy", {31'h0, busy1}, 32'h1);
    drive(1'b0, 1'b0, 32'h0, 32'h0, SzW, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("mid-clear Busy", {31'h0, busy1}, 32'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    // Requests during the restarted sweep must be ignored.
    drive(1'b1, 1'b1, 32'h010, 32'hFFFFFFFF, SzW, 1'b0);
    count_busy(nb, sp);
    check("restart busy cycles", nb, 256);
    check("pulses while busy", sp, 0);
    drive(1'b1, 1'b0, 32'h010, 32'h0, SzW, 1'b0);
    @(posedge clk);
    #1;
    check("post-clear valid", {31'h0, rv1}, 32'h1);
    check("post-clear data", rd1, 32'h0);
    drive(1'b0, 1'b0, 32'h0, 32'h0, SzW, 1'b0);
    @(posedge clk);
    #1;
    check("valid drops", {31'h0, rv1}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
